// File: rtl/jtframe_rom_arb_pkg.sv
// jtframe_rom_arb_pkg: shared FSM states, SDRAM address width and OFFSETS slicing
package jtframe_rom_arb_pkg;
  localparam int SDRAM_AW = 22;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  function automatic logic [SDRAM_AW-1:0] slot_offset(input logic [16*SDRAM_AW-1:0] offsets, input int i);
    return offsets[SDRAM_AW*i +: SDRAM_AW];
  endfunction
endpackage

// File: rtl/jtframe_rom_arb_cache.sv
// jtframe_rom_arb_cache: one-word cache for a single ROM slot with hit compare and byte select
module jtframe_rom_arb_cache
  import jtframe_rom_arb_pkg::*;
#(
  parameter int AW  = 22,
  parameter bit IS8 = 1'b0
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                we,
  input  logic [SDRAM_AW-1:0] we_tag,
  input  logic [15:0]         we_data,
  input  logic                cs,
  input  logic [AW-1:0]       addr,
  output logic [SDRAM_AW-1:0] wa,
  output logic                ok,
  output logic [15:0]         dout
);
  logic [SDRAM_AW-1:0] tag_q;
  logic [15:0]         data_q;
  logic                valid_q;
  assign wa   = IS8 ? SDRAM_AW'(addr >> 1) : SDRAM_AW'(addr);
  assign ok   = cs && valid_q && tag_q == wa;
  assign dout = IS8 ? {8'h00, addr[0] ? data_q[15:8] : data_q[7:0]} : data_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tag_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= clr ? 1'b0 : we ? 1'b1 : valid_q;
      tag_q   <= we ? we_tag : tag_q;
      data_q  <= we ? we_data : data_q;
    end
endmodule

// File: rtl/jtframe_rom_arb_n.sv
// jtframe_rom_arb_n: SLOTS-client ROM arbiter with per-slot one-word caches onto one SDRAM read port.
// Define JTFRAME_ROMARB_STATS_EN to add per-slot saturating grant counters on miss_cnt.
module jtframe_rom_arb_n
  import jtframe_rom_arb_pkg::*;
#(
  parameter int                          SLOTS   = 4,
  parameter int                          AW      = 22,
  parameter logic [SLOTS-1:0]            DW8     = '0,
  parameter logic [SLOTS*SDRAM_AW-1:0]   OFFSETS = '0,
  parameter int                          RR      = 0
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  downloading,
  input  logic [SLOTS-1:0]      slot_cs,
  input  logic [SLOTS*AW-1:0]   slot_addr,
  output logic [SLOTS-1:0]      slot_ok,
  output logic [SLOTS*16-1:0]   slot_dout,
  output logic                  sdram_req,
  output logic [SDRAM_AW-1:0]   sdram_addr,
  input  logic                  sdram_ack,
  input  logic                  data_rdy,
  input  logic [15:0]           data_read
`ifdef JTFRAME_ROMARB_STATS_EN
  ,
  output logic [SLOTS*16-1:0]   miss_cnt
`endif
);
  localparam logic [16*SDRAM_AW-1:0] OFF_ALL = (16*SDRAM_AW)'(OFFSETS);
  state_e              state_q, state_d;
  logic [3:0]          gnt_q, gnt_d, ptr_q, ptr_d, win;
  logic [SDRAM_AW-1:0] addr_q, addr_d, wa_q, wa_d, win_addr, win_wa;
  logic [SDRAM_AW-1:0] wa [SLOTS];
  logic [SLOTS-1:0]    miss;
  logic                found, fill;
  assign miss       = slot_cs & ~slot_ok & {SLOTS{~downloading}};
  assign fill       = state_q == WAIT && data_rdy && !downloading;
  assign sdram_req  = state_q == REQ;
  assign sdram_addr = addr_q;
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    jtframe_rom_arb_cache #(.AW(AW), .IS8(DW8[i])) u_cache (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (downloading),
      .we      (fill && gnt_q == 4'(i)),
      .we_tag  (wa_q),
      .we_data (data_read),
      .cs      (slot_cs[i]),
      .addr    (slot_addr[AW*i +: AW]),
      .wa      (wa[i]),
      .ok      (slot_ok[i]),
      .dout    (slot_dout[16*i +: 16])
    );
  end
  // Round-robin scans slots above the pointer first, then wraps to slot 0
  always_comb begin
    found    = 1'b0;
    win      = '0;
    win_wa   = '0;
    win_addr = '0;
    for (int s = 0; s < SLOTS; s++)
      if (!found && miss[s] && (RR == 0 || 4'(s) > ptr_q)) begin
        found = 1'b1;
        win   = 4'(s);
      end
    for (int s = 0; s < SLOTS; s++)
      if (!found && miss[s]) begin
        found = 1'b1;
        win   = 4'(s);
      end
    for (int s = 0; s < SLOTS; s++)
      if (win == 4'(s)) begin
        win_wa   = wa[s];
        win_addr = slot_offset(OFF_ALL, s) + wa[s];
      end
  end
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    wa_d    = wa_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = REQ;
        gnt_d   = win;
        addr_d  = win_addr;
        wa_d    = win_wa;
        ptr_d   = RR != 0 ? win : ptr_q;
      end
      REQ:     state_d = downloading ? IDLE : sdram_ack ? WAIT : REQ;
      WAIT:    state_d = data_rdy ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= 4'(SLOTS-1);
      addr_q  <= '0;
      wa_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      wa_q    <= wa_d;
    end
`ifdef JTFRAME_ROMARB_STATS_EN
  logic dl_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dl_q <= 1'b0;
    else dl_q <= downloading;
  for (genvar i = 0; i < SLOTS; i++) begin : g_cnt
    logic [15:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt_q <= '0;
      else if (downloading && !dl_q) cnt_q <= '0;
      else if (state_q == IDLE && found && win == 4'(i) && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    assign miss_cnt[16*i +: 16] = cnt_q;
  end
`endif
endmodule

// File: tb/tb_jtframe_rom_arb_n.sv
// tb_jtframe_rom_arb_n: fixed-priority and round-robin arbiters driven side by side against a behavioural model
module tb_jtframe_rom_arb_n;
  localparam int S = 4;
  localparam logic [S-1:0]    DW8  = 4'b0001;
  localparam logic [S*22-1:0] OFFS = {22'h200000, 22'h3F0000, 22'h010000, 22'h000000};

  logic clk = 1'b0, rst_n;
  logic dl;
  logic [S-1:0]    cs;
  logic [S*22-1:0] addr;
  logic            ack [2], rdy [2];
  logic [15:0]     rd [2];
  logic [S-1:0]    ok [2];
  logic [S*16-1:0] dout [2];
  logic            req [2];
  logic [21:0]     sa [2];
`ifdef JTFRAME_ROMARB_STATS_EN
  logic [S*16-1:0] mc [2];
`endif

  always #5 clk = ~clk;

  jtframe_rom_arb_n #(.SLOTS(S), .AW(22), .DW8(DW8), .OFFSETS(OFFS), .RR(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .downloading(dl), .slot_cs(cs), .slot_addr(addr),
    .slot_ok(ok[0]), .slot_dout(dout[0]), .sdram_req(req[0]), .sdram_addr(sa[0]),
    .sdram_ack(ack[0]), .data_rdy(rdy[0]), .data_read(rd[0])
`ifdef JTFRAME_ROMARB_STATS_EN
    , .miss_cnt(mc[0])
`endif
  );
  jtframe_rom_arb_n #(.SLOTS(S), .AW(22), .DW8(DW8), .OFFSETS(OFFS), .RR(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .downloading(dl), .slot_cs(cs), .slot_addr(addr),
    .slot_ok(ok[1]), .slot_dout(dout[1]), .sdram_req(req[1]), .sdram_addr(sa[1]),
    .sdram_ack(ack[1]), .data_rdy(rdy[1]), .data_read(rd[1])
`ifdef JTFRAME_ROMARB_STATS_EN
    , .miss_cnt(mc[1])
`endif
  );

  // Behavioural model: ph 0 = idle, 1 = request pending, 2 = waiting for data
  bit          mv   [2][S];
  logic [21:0] mtag [2][S];
  logic [15:0] mdat [2][S];
  int          cnt  [2][S];
  int          ph [2], mg [2], ptr [2], dly [2];
  logic [21:0] ma [2];
  bit          pdl [2], preq [2];
  logic [21:0] q0 [$], q1 [$];
  int n_cmp = 0, n_fail = 0;
  int dreq = -1, dwait = -1;
  bit stray = 0, fdata_en = 0;
  logic [15:0] fdata = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, got, exp);
    end
  endtask

  function automatic logic [21:0] wa(input int s);
    logic [21:0] a;
    a = addr[22*s +: 22];
    return DW8[s] ? a >> 1 : a;
  endfunction

  function automatic bit mok(input int m, input int s);
    return cs[s] && mv[m][s] && mtag[m][s] == wa(s);
  endfunction

  function automatic logic [15:0] mdout(input int m, input int s);
    logic [21:0] a;
    a = addr[22*s +: 22];
    return DW8[s] ? {8'h00, a[0] ? mdat[m][s][15:8] : mdat[m][s][7:0]} : mdat[m][s];
  endfunction

  function automatic int pick_dly(input int d);
    return d < 0 ? int'($urandom_range(0, 3)) : d;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      ph[m] = 0; mg[m] = 0; ptr[m] = S-1; dly[m] = 0; ma[m] = '0; pdl[m] = 0; preq[m] = 0;
      for (int s = 0; s < S; s++) begin
        mv[m][s] = 0; mtag[m][s] = '0; mdat[m][s] = '0; cnt[m][s] = 0;
      end
    end
  endtask

  task automatic compare();
    for (int m = 0; m < 2; m++) begin
      logic [S-1:0] eok;
      logic [S*16-1:0] ed;
      for (int s = 0; s < S; s++) begin
        eok[s] = mok(m, s);
        ed[16*s +: 16] = mdout(m, s);
      end
      chk($sformatf("slot_ok[%0d]", m), 64'(ok[m]), 64'(eok));
      chk($sformatf("slot_dout[%0d]", m), 64'(dout[m]), 64'(ed));
      chk($sformatf("sdram_req[%0d]", m), 64'(req[m]), 64'(ph[m] == 1));
      chk($sformatf("sdram_addr[%0d]", m), 64'(sa[m]), 64'(ma[m]));
`ifdef JTFRAME_ROMARB_STATS_EN
      for (int s = 0; s < S; s++) ed[16*s +: 16] = 16'(cnt[m][s]);
      chk($sformatf("miss_cnt[%0d]", m), 64'(mc[m]), 64'(ed));
`endif
      if (req[m] && !preq[m]) begin
        if (m == 0) q0.push_back(sa[m]);
        else q1.push_back(sa[m]);
      end
      preq[m] = req[m];
    end
  endtask

  task automatic advance();
    for (int m = 0; m < 2; m++) begin
      logic [S-1:0] miss;
      int w;
      for (int s = 0; s < S; s++) miss[s] = cs[s] && !mok(m, s) && !dl;
      if (dl) for (int s = 0; s < S; s++) mv[m][s] = 0;
      if (dl && !pdl[m]) for (int s = 0; s < S; s++) cnt[m][s] = 0;
      pdl[m] = dl;
      if (ph[m] == 0) begin
        if (miss != 0) begin
          w = -1;
          for (int k = 1; k <= S; k++) begin
            int j;
            j = (m == 1) ? (ptr[m] + k) % S : k - 1;
            if (w < 0 && miss[j]) w = j;
          end
          ph[m] = 1; mg[m] = w;
          ma[m] = OFFS[22*w +: 22] + wa(w);
          mtag[m][w] = mtag[m][w];
          if (m == 1) ptr[m] = w;
          if (cnt[m][w] < 65535) cnt[m][w]++;
          dly[m] = pick_dly(dreq);
        end
      end else if (ph[m] == 1) begin
        if (dl) ph[m] = 0;
        else if (ack[m]) begin ph[m] = 2; dly[m] = pick_dly(dwait); end
        else if (dly[m] > 0) dly[m]--;
      end else begin
        if (rdy[m]) begin
          if (!dl) begin
            mv[m][mg[m]] = 1;
            mtag[m][mg[m]] = (mg[m] == 0) ? (ma[m] - OFFS[21:0]) : (ma[m] - OFFS[22*mg[m] +: 22]);
            mdat[m][mg[m]] = rd[m];
          end
          ph[m] = 0;
        end else if (dly[m] > 0) dly[m]--;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      ack[m] = ph[m] == 1 && dly[m] == 0;
      rdy[m] = (ph[m] == 2 && dly[m] == 0) || (stray && ph[m] == 0);
      rd[m]  = fdata_en ? fdata : 16'($urandom);
    end
    #1;
    compare();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ph(input int m, input int p, input int lim, input string nm);
    int n = 0;
    do begin step(); n++; end while (ph[m] != p && n < lim);
    if (ph[m] != p) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: timeout after %0d cycles, phase %0d expected %0d", nm, n, ph[m], p);
    end
  endtask

  task automatic randomize_inputs();
    for (int s = 0; s < S; s++) begin
      if ($urandom_range(0, 9) == 0) cs[s] = ~cs[s];
      if ($urandom_range(0, 4) == 0)
        addr[22*s +: 22] = ($urandom_range(0, 7) == 0) ? 22'($urandom) : 22'($urandom_range(0, 5));
    end
    dl = dl ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 99) == 0);
    stray = $urandom_range(0, 49) == 0;
  endtask

  initial begin
    rst_n = 0; dl = 0; cs = '0; addr = '0;
    for (int m = 0; m < 2; m++) begin ack[m] = 0; rdy[m] = 0; rd[m] = '0; end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req", {req[1], req[0]}, 0);
    chk("reset_addr", {sa[1], sa[0]}, 0);
    chk("reset_ok", {ok[1], ok[0]}, 0);
    chk("reset_dout", dout[0] | dout[1], 0);
    rst_n = 1;

    // 16-bit slot 1 miss, then same-cycle hit
    addr[22 +: 22] = 22'h5; cs = 4'b0010; dreq = 2; dwait = 4; fdata_en = 1; fdata = 16'hBEEF;
    wait_ph(0, 1, 10, "t1_req");
    chk("t1_sdram_addr", sa[0], 22'h10005);
    chk("t1_sdram_req", req[0], 1);
    wait_ph(0, 0, 20, "t1_done");
    chk("t1_ok", ok[0][1], 1);
    chk("t1_dout", dout[0][31:16], 16'hBEEF);
    step();
    chk("t1_rehit_ok", ok[0][1], 1);
    chk("t1_rehit_req", req[0], 0);

    // 8-bit slot 0 byte select
    fdata = 16'h12AB; cs = 4'b0001; addr[0 +: 22] = 22'h3;
    wait_ph(0, 1, 10, "t2_req");
    chk("t2_sdram_addr", sa[0], 22'h1);
    wait_ph(0, 0, 20, "t2_done");
    chk("t2_ok_hi", ok[0][0], 1);
    chk("t2_dout_hi", dout[0][15:0], 16'h0012);
    addr[0 +: 22] = 22'h2;
    #1;
    chk("t2_ok_lo", ok[0][0], 1);
    chk("t2_dout_lo", dout[0][15:0], 16'h00AB);
    step();
    chk("t2_no_req", req[0], 0);

    // simultaneous misses on slots 0, 2, 3
    fdata_en = 0; dreq = -1; dwait = -1;
    addr[0 +: 22] = 22'h100; addr[44 +: 22] = 22'h7; addr[66 +: 22] = 22'h9; cs = 4'b1101;
    q0.delete();
    for (int n = 0; n < 200 && !(q0.size() == 3 && ph[0] == 0 && ph[1] == 0); n++) step();
    chk("t3_grants", q0.size(), 3);
    if (q0.size() >= 3) begin
      chk("t3_grant0", q0[0], 22'h000080);
      chk("t3_grant1", q0[1], 22'h3F0007);
      chk("t3_grant2", q0[2], 22'h200009);
    end
    chk("t3_all_ok", ok[0], 4'b1101);

    // round-robin between continuously missing slots 1 and 2
    addr[22 +: 22] = 22'h20; addr[44 +: 22] = 22'h30; cs = 4'b0110;
    q1.delete();
    for (int n = 0; n < 300 && q1.size() < 4; n++) begin
      for (int s = 1; s <= 2; s++) if (mok(1, s)) addr[22*s] = ~addr[22*s];
      step();
    end
    chk("t4_grants", q1.size() >= 4, 1);
    if (q1.size() >= 4) begin
      chk("t4_rr0", q1[0], 22'h010020);
      chk("t4_rr1", q1[1], 22'h3F0030);
      chk("t4_rr2", q1[2], 22'h010021);
      chk("t4_rr3", q1[3], 22'h3F0031);
    end

    // download during REQ
    cs = 4'b0001; addr[0 +: 22] = 22'h200; dreq = 10;
    wait_ph(0, 1, 10, "t5_req");
    dl = 1;
    step();
    chk("t5_req_drop", req[0], 0);
    chk("t5_ok_clear", {ok[1], ok[0]}, 0);
    for (int n = 0; n < 4; n++) begin
      step();
      chk("t5_no_grant", {req[1], req[0]}, 0);
    end
    dl = 0; dreq = -1;

    // download during WAIT
    addr[0 +: 22] = 22'h300; dwait = 3;
    wait_ph(0, 2, 30, "t5b_wait");
    dl = 1;
    wait_ph(0, 0, 20, "t5b_done");
    chk("t5b_discard", ok[0][0], 0);
    dl = 0;
    step();
    chk("t5b_still_invalid", ok[0][0], 0);
    dwait = -1;

    // async reset mid-WAIT, then a stray data_rdy
    addr[0 +: 22] = 22'h400; dwait = 20;
    wait_ph(0, 2, 30, "t6_wait");
    #2 rst_n = 0;
    #1;
    chk("t6_req", {req[1], req[0]}, 0);
    chk("t6_ok", {ok[1], ok[0]}, 0);
    chk("t6_addr", {sa[1], sa[0]}, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    cs = '0; dwait = -1; stray = 1;
    step();
    stray = 0;
    step();
    cs = 4'b0001;
    #1;
    chk("t6_stray_ignored", ok[0][0], 0);
    chk("t6_stray_noreq", req[0], 0);

    // randomized traffic
    cs = 4'b1111;
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
